bit_serializer: RTL and testbench

Parallel-to-serial front end for the bit-stream sequence recognisers. It accepts WIDTH-bit words over a valid/ready handshake and emits them one bit per clock on `x_out`. `x_out` connects directly to a recogniser's serial input `x`. A one-word holding register lets back-to-back words stream without idle gaps, so recogniser patterns that straddle word boundaries are presented exactly as they would appear on a continuous line.

---
 rtl/seq_pkg.sv | 12 +
 rtl/ser_hold_reg.sv | 52 +++++
 rtl/bit_serializer.sv | 115 +++++++++++
 tb/tb_bit_serializer.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/seq_pkg.sv
// Shared types and defaults for the bit-stream front end and recognisers.
package seq_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } ser_state_t;

    localparam int unsigned SER_WIDTH_DEF    = 8;
    localparam logic        SER_IDLE_BIT_DEF = 1'b0;

endpackage

// File: rtl/ser_hold_reg.sv
// One-entry valid/ready holding register with bypass to the load source.
module ser_hold_reg #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] in_data_i,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic             load_i,
    output logic             src_valid_o,
    output logic [WIDTH-1:0] src_data_o,
    output logic             full_o
);

    logic [WIDTH-1:0] hold_q, hold_d;
    logic             full_q, full_d;
    logic             accept;

    // Handshake and load-source selection: a stored word always wins over bypass.
    always_comb begin
        in_ready_o  = !full_q && !rst;
        accept      = in_valid_i && in_ready_o;
        src_valid_o = full_q || accept;
        src_data_o  = full_q ? hold_q : in_data_i;
        full_o      = full_q;
    end

    // Next state: drain on load, capture an accepted word that cannot be bypassed.
    always_comb begin
        hold_d = hold_q;
        full_d = full_q;
        if (load_i && full_q) begin
            full_d = 1'b0;
        end else if (accept && !load_i) begin
            full_d = 1'b1;
            hold_d = in_data_i;
        end
    end

    // Holding register; reset discards any stored word.
    always_ff @(posedge clk) begin
        if (rst) begin
            hold_q <= '0;
            full_q <= 1'b0;
        end else begin
            hold_q <= hold_d;
            full_q <= full_d;
        end
    end

endmodule

// File: rtl/bit_serializer.sv
// Parallel-to-serial front end: WIDTH-bit words in, one registered bit per clock out.
module bit_serializer
    import seq_pkg::*;
#(
    parameter int unsigned WIDTH     = SER_WIDTH_DEF,
    parameter bit          MSB_FIRST = 1'b1,
    parameter logic        IDLE_BIT  = SER_IDLE_BIT_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic             x_out,
    output logic             bit_valid,
    output logic             word_start,
    output logic             busy
);

    localparam int unsigned     CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

    ser_state_t       state_q, state_d;
    logic [WIDTH-1:0] sr_q, sr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             x_out_q, x_out_d;
    logic             bit_valid_q, bit_valid_d;
    logic             word_start_q, word_start_d;

    logic             load_evt;
    logic             src_valid;
    logic [WIDTH-1:0] src_data;
    logic             hold_full;

    function automatic logic out_bit(input logic [WIDTH-1:0] v);
        return MSB_FIRST ? v[WIDTH-1] : v[0];
    endfunction

    function automatic logic [WIDTH-1:0] shift_on(input logic [WIDTH-1:0] v);
        return MSB_FIRST ? {v[WIDTH-2:0], 1'b0} : {1'b0, v[WIDTH-1:1]};
    endfunction

    ser_hold_reg #(.WIDTH(WIDTH)) u_hold (
        .clk        (clk),
        .rst        (rst),
        .in_data_i  (in_data),
        .in_valid_i (in_valid),
        .in_ready_o (in_ready),
        .load_i     (load_evt),
        .src_valid_o(src_valid),
        .src_data_o (src_data),
        .full_o     (hold_full)
    );

    // A new word may enter the shifter when idle or while the last bit is on the line.
    always_comb begin
        load_evt = (state_q == IDLE) || (cnt_q == LAST);
    end

    // FSM next state. The output bit is registered, so on load bit 0 goes straight
    // to x_out and sr keeps only the remaining bits, pre-shifted.
    always_comb begin
        state_d      = state_q;
        sr_d         = sr_q;
        cnt_d        = cnt_q;
        x_out_d      = IDLE_BIT;
        bit_valid_d  = 1'b0;
        word_start_d = 1'b0;
        if (load_evt) begin
            cnt_d = '0;
            if (src_valid) begin
                state_d      = SHIFT;
                x_out_d      = out_bit(src_data);
                sr_d         = shift_on(src_data);
                bit_valid_d  = 1'b1;
                word_start_d = 1'b1;
            end else begin
                state_d = IDLE;
            end
        end else begin
            cnt_d       = cnt_q + 1'b1;
            x_out_d     = out_bit(sr_q);
            sr_d        = shift_on(sr_q);
            bit_valid_d = 1'b1;
        end
    end

    // State, shifter and registered serial outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            sr_q         <= '0;
            cnt_q        <= '0;
            x_out_q      <= IDLE_BIT;
            bit_valid_q  <= 1'b0;
            word_start_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            sr_q         <= sr_d;
            cnt_q        <= cnt_d;
            x_out_q      <= x_out_d;
            bit_valid_q  <= bit_valid_d;
            word_start_q <= word_start_d;
        end
    end

    // Output mapping.
    always_comb begin
        x_out      = x_out_q;
        bit_valid  = bit_valid_q;
        word_start = word_start_q;
        busy       = (state_q == SHIFT) || hold_full;
    end

endmodule

// File: tb/tb_bit_serializer.sv
// Directed self-checking bench for bit_serializer (MSB-first and LSB-first instances).
module tb_bit_serializer;

    logic       clk;
    logic       rst;

    logic [7:0] m_in_data, l_in_data;
    logic       m_in_valid, l_in_valid;
    logic       m_in_ready, l_in_ready;
    logic       m_x_out, l_x_out;
    logic       m_bit_valid, l_bit_valid;
    logic       m_word_start, l_word_start;
    logic       m_busy, l_busy;

    int unsigned n_checks;
    int unsigned n_fail;

    logic [7:0] wq [0:2];

    typedef struct {
        logic        sel;      // 0 = MSB-first instance, 1 = LSB-first instance
        logic [7:0]  data;
        logic [7:0]  seq;      // expected bits in emission order, seq[7] first
        int unsigned det;      // expected 101 detections within the word
    } vec_t;

    vec_t vecs [5];

    bit_serializer #(.WIDTH(8), .MSB_FIRST(1'b1), .IDLE_BIT(1'b0)) dut_msb (
        .clk       (clk),
        .rst       (rst),
        .in_data   (m_in_data),
        .in_valid  (m_in_valid),
        .in_ready  (m_in_ready),
        .x_out     (m_x_out),
        .bit_valid (m_bit_valid),
        .word_start(m_word_start),
        .busy      (m_busy)
    );

    bit_serializer #(.WIDTH(8), .MSB_FIRST(1'b0), .IDLE_BIT(1'b0)) dut_lsb (
        .clk       (clk),
        .rst       (rst),
        .in_data   (l_in_data),
        .in_valid  (l_in_valid),
        .in_ready  (l_in_ready),
        .x_out     (l_x_out),
        .bit_valid (l_bit_valid),
        .word_start(l_word_start),
        .busy      (l_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic sel, input logic v, input logic [7:0] d);
        if (sel) begin
            l_in_valid = v;
            l_in_data  = d;
        end else begin
            m_in_valid = v;
            m_in_data  = d;
        end
    endtask

    task automatic sample(input logic sel, output logic xo, output logic bv,
                          output logic ws, output logic rdy, output logic bsy);
        xo  = sel ? l_x_out      : m_x_out;
        bv  = sel ? l_bit_valid  : m_bit_valid;
        ws  = sel ? l_word_start : m_word_start;
        rdy = sel ? l_in_ready   : m_in_ready;
        bsy = sel ? l_busy       : m_busy;
    endtask

    // One word from idle; checks every bit, the pulse and the return to idle.
    task automatic single_word(input vec_t v);
        logic xo, bv, ws, rdy, bsy;
        logic [2:0] win;
        int unsigned det;
        win = '0;
        det = 0;
        drive(v.sel, 1'b1, v.data);
        sample(v.sel, xo, bv, ws, rdy, bsy);
        check("single_pre_ready", 32'(rdy), 32'd1);
        step();
        drive(v.sel, 1'b0, 8'h00);
        for (int i = 0; i < 8; i++) begin
            sample(v.sel, xo, bv, ws, rdy, bsy);
            check($sformatf("single_%02h_bit%0d", v.data, i), 32'(xo), 32'(v.seq[7-i]));
            check("single_bit_valid", 32'(bv), 32'd1);
            check("single_word_start", 32'(ws), 32'(i == 0));
            win = {win[1:0], xo};
            if (i >= 2 && win == 3'b101) det++;
            step();
        end
        sample(v.sel, xo, bv, ws, rdy, bsy);
        check("single_after_valid", 32'(bv), 32'd0);
        check("single_after_x", 32'(xo), 32'd0);
        check("single_after_busy", 32'(bsy), 32'd0);
        check($sformatf("single_%02h_det101", v.data), det, v.det);
    endtask

    // Offer wq[0..n-1] back to back on the MSB-first instance and collect the stream.
    task automatic run_stream(input int unsigned n, input logic [23:0] exp_stream,
                              input logic [23:0] exp_ws, input int unsigned exp_low);
        logic xo, bv, ws, rdy, bsy, fire;
        logic [23:0] stream, wsm;
        int unsigned idx, nbits, low;
        logic started, ended, gap;
        idx = 0; nbits = 0; low = 0;
        stream = '0; wsm = '0;
        started = 1'b0; ended = 1'b0; gap = 1'b0;
        for (int cyc = 0; cyc < 60; cyc++) begin
            sample(1'b0, xo, bv, ws, rdy, bsy);
            if (bv) begin
                if (ended) gap = 1'b1;
                if (ws) wsm[nbits] = 1'b1;
                stream = {stream[22:0], xo};
                nbits++;
                started = 1'b1;
            end else if (started) begin
                ended = 1'b1;
            end
            if (idx < n) drive(1'b0, 1'b1, wq[idx]);
            else         drive(1'b0, 1'b0, 8'h00);
            rdy = m_in_ready;
            if (!rdy) low++;
            fire = (idx < n) && rdy;
            step();
            if (fire) idx++;
        end
        check($sformatf("stream%0d_accepted", n), idx, n);
        check($sformatf("stream%0d_nbits", n), nbits, 8 * n);
        check($sformatf("stream%0d_bits", n), 32'(stream), 32'(exp_stream));
        check($sformatf("stream%0d_word_start", n), 32'(wsm), 32'(exp_ws));
        check($sformatf("stream%0d_gap", n), 32'(gap), 32'd0);
        check($sformatf("stream%0d_ready_low_cycles", n), low, exp_low);
        check($sformatf("stream%0d_idle_busy", n), 32'(m_busy), 32'd0);
    endtask

    initial begin
        logic xo, bv, ws, rdy, bsy;
        int unsigned bv_count;

        n_checks = 0;
        n_fail   = 0;

        vecs[0] = '{sel: 1'b0, data: 8'hA0, seq: 8'hA0, det: 1};
        vecs[1] = '{sel: 1'b0, data: 8'h3C, seq: 8'h3C, det: 0};
        vecs[2] = '{sel: 1'b0, data: 8'hFF, seq: 8'hFF, det: 0};
        vecs[3] = '{sel: 1'b1, data: 8'h01, seq: 8'h80, det: 0};
        vecs[4] = '{sel: 1'b1, data: 8'hA0, seq: 8'h05, det: 1};

        rst = 1'b1;
        m_in_valid = 1'b0; m_in_data = 8'h00;
        l_in_valid = 1'b0; l_in_data = 8'h00;

        // Reset held for three cycles, then ten idle cycles.
        for (int i = 0; i < 3; i++) begin
            step();
            check("reset_in_ready", 32'(m_in_ready), 32'd0);
            check("reset_x_out", 32'(m_x_out), 32'd0);
            check("reset_bit_valid", 32'(m_bit_valid), 32'd0);
            check("reset_busy", 32'(m_busy), 32'd0);
        end
        rst = 1'b0;
        #1;
        check("post_reset_in_ready", 32'(m_in_ready), 32'd1);
        check("post_reset_word_start", 32'(m_word_start), 32'd0);
        for (int i = 0; i < 10; i++) begin
            step();
            check("idle_x_out", 32'(m_x_out), 32'd0);
            check("idle_bit_valid", 32'(m_bit_valid), 32'd0);
            check("idle_busy", 32'(m_busy), 32'd0);
        end

        foreach (vecs[i]) begin
            single_word(vecs[i]);
            step();
        end

        // Back-to-back pair: bypass then hold, 16 contiguous bits.
        wq[0] = 8'hA5; wq[1] = 8'h5A; wq[2] = 8'h00;
        run_stream(2, 24'h00A55A, 24'h000101, 7);

        // Three words offered continuously: the third stalls until hold drains.
        wq[0] = 8'hA5; wq[1] = 8'h5A; wq[2] = 8'hFF;
        run_stream(3, 24'hA55AFF, 24'h010101, 14);

        // Reset at bit 3 of A5 with 5A waiting in hold.
        drive(1'b0, 1'b1, 8'hA5);
        step();
        drive(1'b0, 1'b1, 8'h5A);
        check("midrst_hold_ready", 32'(m_in_ready), 32'd1);
        step();
        drive(1'b0, 1'b0, 8'h00);
        step();
        step();
        sample(1'b0, xo, bv, ws, rdy, bsy);
        check("midrst_bit3", 32'(xo), 32'd0);
        check("midrst_bit3_valid", 32'(bv), 32'd1);
        check("midrst_hold_full_ready", 32'(rdy), 32'd0);
        rst = 1'b1;
        #1;
        check("midrst_ready_in_reset", 32'(m_in_ready), 32'd0);
        step();
        sample(1'b0, xo, bv, ws, rdy, bsy);
        check("midrst_x_out", 32'(xo), 32'd0);
        check("midrst_bit_valid", 32'(bv), 32'd0);
        check("midrst_busy", 32'(bsy), 32'd0);
        check("midrst_word_start", 32'(ws), 32'd0);
        rst = 1'b0;
        bv_count = 0;
        for (int i = 0; i < 12; i++) begin
            step();
            if (m_bit_valid) bv_count++;
        end
        check("midrst_no_resume", bv_count, 0);
        check("midrst_final_busy", 32'(m_busy), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
